// File: rtl/vmicro16_apb_shared_mem_if.sv
// APB bus bundle between a cluster master port and the shared-memory completer.
interface vmicro16_apb_shared_mem_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 16
);
  logic [BUS_WIDTH-1:0]  paddr;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;

  modport master (output paddr, pwrite, psel, penable, pwdata,
                  input  prdata, pready);
  modport slave  (input  paddr, pwrite, psel, penable, pwdata,
                  output prdata, pready);
endinterface

// File: rtl/vmicro16_apb_shared_mem.sv
// APB completer serving a shared word RAM plus test-and-set lock registers,
// with a configurable number of access-phase wait states.
module vmicro16_apb_shared_mem #(
  parameter int              BUS_WIDTH   = 16,
  parameter int              DATA_WIDTH  = 16,
  parameter int              MEM_DEPTH   = 256,
  parameter int              NLOCKS      = 8,
  parameter logic [15:0]     LOCK_BASE   = 16'h0100,
  parameter int              WAIT_STATES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  vmicro16_apb_shared_mem_if.slave s_apb,
  output logic [NLOCKS-1:0]        locks
);
  localparam int MEM_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LOCK_W = (NLOCKS > 1) ? $clog2(NLOCKS) : 1;
  localparam int CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  localparam logic [BUS_WIDTH-1:0] MEM_TOP   = BUS_WIDTH'(MEM_DEPTH);
  localparam logic [BUS_WIDTH-1:0] LOCK_LO   = BUS_WIDTH'(LOCK_BASE);
  localparam logic [BUS_WIDTH-1:0] LOCK_HI   = BUS_WIDTH'(LOCK_BASE + NLOCKS);
  localparam logic [CNT_W-1:0]     CNT_START = CNT_W'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [NLOCKS-1:0]     locks_q, locks_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  is_ram, is_lock, pready, mem_we;
  logic [LOCK_W-1:0]     lock_idx;
  logic [MEM_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] rd_val;

  assign is_ram   = (s_apb.paddr < MEM_TOP);
  assign is_lock  = (s_apb.paddr >= LOCK_LO) && (s_apb.paddr < LOCK_HI);
  assign lock_idx = LOCK_W'(s_apb.paddr - LOCK_LO);
  assign mem_idx  = s_apb.paddr[MEM_W-1:0];
  assign pready   = (state_q == ACCESS) && (cnt_q == '0);

  // Lock reads return the bit as it stood at setup; the set happens at completion.
  always_comb begin
    rd_val = '0;
    if (is_ram)
      rd_val = mem_q[mem_idx];
    else if (is_lock)
      rd_val = {{(DATA_WIDTH-1){1'b0}}, locks_q[lock_idx]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prdata_d = prdata_q;
    locks_d  = locks_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_apb.psel && !s_apb.penable) begin
          state_d  = ACCESS;
          cnt_d    = CNT_START;
          prdata_d = s_apb.pwrite ? '0 : rd_val;
        end
      end
      ACCESS: begin
        if (!s_apb.psel) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end else if (s_apb.penable) begin
          state_d = IDLE;
          if (s_apb.pwrite) begin
            if (is_ram)
              mem_we = 1'b1;
            else if (is_lock)
              locks_d[lock_idx] = s_apb.pwdata[0];
          end else if (is_lock) begin
            locks_d[lock_idx] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prdata_q <= '0;
      locks_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prdata_q <= prdata_d;
      locks_q  <= locks_d;
    end
  end

  // RAM contents survive reset; only the commit is suppressed.
  always_ff @(posedge clk) begin
    if (mem_we && !reset)
      mem_q[mem_idx] <= s_apb.pwdata;
  end

  assign s_apb.pready = pready;
  assign s_apb.prdata = prdata_q;
  assign locks        = locks_q;
endmodule

// File: tb/tb_vmicro16_apb_shared_mem.sv
// Directed bench: a zero-wait and a two-wait instance of the shared memory completer.
module tb_vmicro16_apb_shared_mem;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] locks0, locks2;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vmicro16_apb_shared_mem_if #(.BUS_WIDTH(16), .DATA_WIDTH(16)) if0 ();
  vmicro16_apb_shared_mem_if #(.BUS_WIDTH(16), .DATA_WIDTH(16)) if2 ();

  vmicro16_apb_shared_mem #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .s_apb(if0), .locks(locks0));
  vmicro16_apb_shared_mem #(.WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .s_apb(if2), .locks(locks2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input int w, input logic sel, input logic en, input logic wr,
                         input logic [15:0] a, input logic [15:0] d);
    if (w == 0) begin
      if0.psel = sel; if0.penable = en; if0.pwrite = wr; if0.paddr = a; if0.pwdata = d;
    end else begin
      if2.psel = sel; if2.penable = en; if2.pwrite = wr; if2.paddr = a; if2.pwdata = d;
    end
  endtask

  function automatic logic get_ready(input int w);
    return (w == 0) ? if0.pready : if2.pready;
  endfunction

  function automatic logic [15:0] get_rdata(input int w);
    return (w == 0) ? if0.prdata : if2.prdata;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a posedge; returns #1 after the completion edge with the bus idle.
  task automatic xfer(input string tag, input int w, input logic wr, input logic [15:0] a,
                      input logic [15:0] d, input int exp_wait, output logic [15:0] rdata);
    int waits;
    set_bus(w, 1'b1, 1'b0, wr, a, d);
    tick();
    set_bus(w, 1'b1, 1'b1, wr, a, d);
    waits = 0;
    while (!get_ready(w) && waits < 20) begin
      waits++;
      tick();
    end
    check({tag, "_waits"}, waits, exp_wait);
    rdata = get_rdata(w);
    tick();
    set_bus(w, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    logic [15:0] rd;
    set_bus(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_bus(2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    reset = 1'b1;
    tick(); tick();
    check("rst_pready0", get_ready(0), 1'b0);
    check("rst_prdata0", get_rdata(0), 16'h0000);
    check("rst_locks0", locks0, 8'h00);
    check("rst_pready2", get_ready(2), 1'b0);
    check("rst_locks2", locks2, 8'h00);
    reset = 1'b0;
    tick();

    // zero-wait instance
    xfer("t1_wr", 0, 1'b1, 16'h0005, 16'h1234, 0, rd);
    xfer("t1_rd", 0, 1'b0, 16'h0005, 16'h0000, 0, rd);
    check("t1_rdata", rd, 16'h1234);
    check("t1_hold", get_rdata(0), 16'h1234);

    // two-wait instance
    xfer("t2_wr", 2, 1'b1, 16'h00FF, 16'hBEEF, 2, rd);
    check("t2_wr_rdata0", rd, 16'h0000);
    xfer("t2_rd", 2, 1'b0, 16'h00FF, 16'h0000, 2, rd);
    check("t2_rdata", rd, 16'hBEEF);

    xfer("t3_rd1", 2, 1'b0, 16'h0100, 16'h0000, 2, rd);
    check("t3_rd1_val", rd, 16'h0000);
    check("t3_lock_set", locks2, 8'h01);
    xfer("t3_rd2", 2, 1'b0, 16'h0100, 16'h0000, 2, rd);
    check("t3_rd2_val", rd, 16'h0001);
    xfer("t3_wr0", 2, 1'b1, 16'h0100, 16'h0000, 2, rd);
    check("t3_lock_clr", locks2, 8'h00);
    xfer("t3_rd3", 2, 1'b0, 16'h0100, 16'h0000, 2, rd);
    check("t3_rd3_val", rd, 16'h0000);
    check("t3_lock_reset", locks2, 8'h01);
    xfer("t3_rd7", 2, 1'b0, 16'h0107, 16'h0000, 2, rd);
    check("t3_rd7_val", rd, 16'h0000);
    check("t3_lock7", locks2, 8'h81);

    xfer("t4_wr5", 2, 1'b1, 16'h0005, 16'h1234, 2, rd);
    xfer("t4_wr_unm", 2, 1'b1, 16'h0200, 16'hFFFF, 2, rd);
    xfer("t4_rd_unm", 2, 1'b0, 16'h0200, 16'h0000, 2, rd);
    check("t4_unm_val", rd, 16'h0000);
    xfer("t4_wr_108", 2, 1'b1, 16'h0108, 16'hFFFF, 2, rd);
    check("t4_locks", locks2, 8'h81);
    xfer("t4_rd5", 2, 1'b0, 16'h0005, 16'h0000, 2, rd);
    check("t4_mem5", rd, 16'h1234);

    // illegal enable in IDLE must be ignored
    set_bus(2, 1'b1, 1'b1, 1'b1, 16'h0005, 16'h7777);
    tick();
    check("idle_en_rdy_a", get_ready(2), 1'b0);
    tick(); tick(); tick();
    check("idle_en_rdy_b", get_ready(2), 1'b0);
    set_bus(2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    xfer("idle_rd5", 2, 1'b0, 16'h0005, 16'h0000, 2, rd);
    check("idle_mem5", rd, 16'h1234);

    // reset during a wait cycle, held past where completion would fall
    set_bus(2, 1'b1, 1'b0, 1'b1, 16'h0005, 16'h5555);
    tick();
    set_bus(2, 1'b1, 1'b1, 1'b1, 16'h0005, 16'h5555);
    tick();
    reset = 1'b1;
    tick();
    check("t5_pready", get_ready(2), 1'b0);
    check("t5_locks", locks2, 8'h00);
    tick(); tick();
    set_bus(2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    reset = 1'b0;
    tick();
    xfer("t5_rd5", 2, 1'b0, 16'h0005, 16'h0000, 2, rd);
    check("t5_mem5", rd, 16'h1234);

    // abort mid-wait on a lock read
    set_bus(2, 1'b1, 1'b0, 1'b0, 16'h0101, 16'h0000);
    tick();
    set_bus(2, 1'b1, 1'b1, 1'b0, 16'h0101, 16'h0000);
    tick();
    set_bus(2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick(); tick(); tick();
    check("t6_abort_locks", locks2, 8'h00);
    check("t6_abort_rdy", get_ready(2), 1'b0);
    xfer("t6_rd101", 2, 1'b0, 16'h0101, 16'h0000, 2, rd);
    check("t6_rd101_val", rd, 16'h0000);
    check("t6_lock1", locks2, 8'h02);

    // back-to-back writes, no idle cycle between
    xfer("t6_b2b_a", 2, 1'b1, 16'h0010, 16'hA1A1, 2, rd);
    xfer("t6_b2b_b", 2, 1'b1, 16'h0011, 16'hB2B2, 2, rd);
    xfer("t6_rd10", 2, 1'b0, 16'h0010, 16'h0000, 2, rd);
    check("t6_mem10", rd, 16'hA1A1);
    xfer("t6_rd11", 2, 1'b0, 16'h0011, 16'h0000, 2, rd);
    check("t6_mem11", rd, 16'hB2B2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
